// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the SRAM-backed data memory controller.
//   state_e       : controller FSM states
//   MEM_BASE_ADDR : default start of the data space in CPU byte addresses
//   SRAM_DW       : external SRAM data bus width
package mem_ctrl_pkg;
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACC_HI = 2'd1,
      ACC_LO = 2'd2,
      DONE   = 2'd3
   } state_e;

   localparam int MEM_BASE_ADDR = 1024;
   localparam int SRAM_DW       = 16;
endpackage

// File: rtl/sram_mem_controller.sv
// sram_mem_controller: bridges the MEM-stage word request interface to a slow
// 16-bit external SRAM. Each 32-bit access becomes two halfword accesses
// (high half at the even halfword address, low half at the odd one), each
// lasting WAIT_CYCLES+1 cycles. ready stays low while busy so the pipeline
// freezes until the access completes.
// Ports:
//   clk, rst            clock, async active-low reset
//   mem_r_en, mem_w_en  load / store request (held while ready=0)
//   address             CPU byte address
//   dataToWrite         store data
//   result              load data, valid from DONE until the next completed read
//   ready               0 while an access is in flight
//   sram_addr           SRAM halfword address
//   sram_dq_out/_in     SRAM write / read data
//   sram_dq_oe          1 = controller drives the SRAM data bus
//   sram_we_n           active-low SRAM write strobe
module sram_mem_controller
   import mem_ctrl_pkg::*;
#(
   parameter int BASE_ADDR   = MEM_BASE_ADDR,
   parameter int SRAM_AW     = 18,
   parameter int WAIT_CYCLES = 1   // legal range 1..7
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 mem_r_en,
   input  logic                 mem_w_en,
   input  logic [31:0]          address,
   input  logic [31:0]          dataToWrite,
   output logic [31:0]          result,
   output logic                 ready,
   output logic [SRAM_AW-1:0]   sram_addr,
   output logic [SRAM_DW-1:0]   sram_dq_out,
   input  logic [SRAM_DW-1:0]   sram_dq_in,
   output logic                 sram_dq_oe,
   output logic                 sram_we_n
);

   localparam logic [2:0] LAST = 3'(WAIT_CYCLES);

   state_e               r_state;
   logic [2:0]           r_cnt;
   logic                 r_is_wr;
   logic [SRAM_AW-2:0]   r_waddr;
   logic [31:0]          r_wdata;
   logic [SRAM_DW-1:0]   r_hi;
   logic [31:0]          r_result;
   logic [SRAM_AW-1:0]   r_sram_addr;
   logic [SRAM_DW-1:0]   r_dq_out;
   logic                 r_dq_oe;
   logic                 r_we_n;

   logic                 w_req;
   logic [31:0]          w_diff;
   logic [SRAM_AW-2:0]   w_waddr;
   logic [2:0]           w_cnt_nxt;
   logic                 w_last;

   // Word index relative to the data base; wraps modulo 2^32 and then again
   // to the SRAM size by truncation.
   assign w_diff    = address - 32'(BASE_ADDR);
   assign w_waddr   = w_diff[SRAM_AW:2];
   assign w_req     = mem_r_en | mem_w_en;
   assign w_cnt_nxt = r_cnt + 3'd1;
   assign w_last    = (r_cnt == LAST);

   wire w_unused = ^{w_diff[1:0], w_diff[31:SRAM_AW+1]};

   // Request is combinationally visible in IDLE so the pipeline stalls on
   // the same cycle the request appears.
   assign ready = ~(((r_state == IDLE) & w_req) |
                    (r_state == ACC_HI) | (r_state == ACC_LO));

   assign result      = r_result;
   assign sram_addr   = r_sram_addr;
   assign sram_dq_out = r_dq_out;
   assign sram_dq_oe  = r_dq_oe;
   assign sram_we_n   = r_we_n;

   // Bus outputs are registered, so each branch loads the value the bus
   // must carry in the following cycle. The strobe is released one cycle
   // before the access ends so address and data hold past its rising edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= IDLE;
         r_cnt       <= 3'd0;
         r_is_wr     <= 1'b0;
         r_waddr     <= '0;
         r_wdata     <= 32'd0;
         r_hi        <= '0;
         r_result    <= 32'd0;
         r_sram_addr <= '0;
         r_dq_out    <= '0;
         r_dq_oe     <= 1'b0;
         r_we_n      <= 1'b1;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_req) begin
                  r_state     <= ACC_HI;
                  r_cnt       <= 3'd0;
                  r_is_wr     <= mem_w_en;   // write wins when both set
                  r_waddr     <= w_waddr;
                  r_wdata     <= dataToWrite;
                  r_sram_addr <= {w_waddr, 1'b0};
                  r_dq_oe     <= mem_w_en;
                  r_we_n      <= ~mem_w_en;  // counter 0 < WAIT_CYCLES
                  if (mem_w_en) r_dq_out <= dataToWrite[31:16];
               end
            end
            ACC_HI, ACC_LO: begin
               if (!w_last) begin
                  r_cnt  <= w_cnt_nxt;
                  r_we_n <= ~(r_is_wr & (w_cnt_nxt < LAST));
               end else begin
                  r_cnt <= 3'd0;
                  if (r_state == ACC_HI) begin
                     r_state     <= ACC_LO;
                     r_sram_addr <= {r_waddr, 1'b1};
                     r_we_n      <= ~r_is_wr;
                     if (r_is_wr) r_dq_out <= r_wdata[15:0];
                     else         r_hi     <= sram_dq_in;
                  end else begin
                     r_state <= DONE;
                     r_dq_oe <= 1'b0;
                     r_we_n  <= 1'b1;
                     // Both halves commit together so result never shows
                     // a half-updated word.
                     if (!r_is_wr) r_result <= {r_hi, sram_dq_in};
                  end
               end
            end
            DONE:    r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sram_mem_controller.sv
module tb_sram_mem_controller;
   localparam int AW = 18;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          mem_r_en = 1'b0, mem_w_en = 1'b0;
   logic [31:0]   address = 32'd0, dataToWrite = 32'd0;
   logic [31:0]   result;
   logic          ready;
   logic [AW-1:0] sram_addr;
   logic [15:0]   sram_dq_out, sram_dq_in;
   logic          sram_dq_oe, sram_we_n;

   logic [15:0]   mem [0:(1<<AW)-1];
   int            total = 0, bad = 0;
   int            strobes = 0;
   int            s0, lows;
   logic [31:0]   res;

   always #5 clk = ~clk;

   sram_mem_controller #(.BASE_ADDR(1024), .SRAM_AW(AW), .WAIT_CYCLES(1)) dut (
      .clk(clk), .rst(rst), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
      .address(address), .dataToWrite(dataToWrite), .result(result),
      .ready(ready), .sram_addr(sram_addr), .sram_dq_out(sram_dq_out),
      .sram_dq_in(sram_dq_in), .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n)
   );

   // SRAM model: async read, write committed on a clock edge while strobed.
   assign sram_dq_in = mem[sram_addr];
   always @(posedge clk) if (!sram_we_n && sram_dq_oe) mem[sram_addr] <= sram_dq_out;
   always @(negedge clk) if (!sram_we_n) strobes <= strobes + 1;

   task chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Issue one request from IDLE, count stalled cycles, capture result in DONE,
   // then drop the enables after the edge leaving DONE.
   task do_req(input logic wr, input logic rd, input logic [31:0] a,
               input logic [31:0] d, output int n_low, output logic [31:0] r_done);
      @(posedge clk); #1;
      mem_w_en = wr; mem_r_en = rd; address = a; dataToWrite = d;
      n_low = 0;
      @(negedge clk);
      while (!ready && n_low < 50) begin
         n_low++;
         @(negedge clk);
      end
      r_done = result;
      @(posedge clk); #1;
      mem_w_en = 1'b0; mem_r_en = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < (1<<AW); i++) mem[i] = 16'h0000;

      // reset state
      repeat (2) @(negedge clk);
      chk("rst_result", result, 32'd0);
      chk("rst_addr",   32'(sram_addr), 32'd0);
      chk("rst_dqout",  32'(sram_dq_out), 32'd0);
      chk("rst_oe",     32'(sram_dq_oe), 32'd0);
      chk("rst_wen",    32'(sram_we_n), 32'd1);
      @(posedge clk); #1 rst = 1'b1;
      @(negedge clk);
      chk("idle_ready", 32'(ready), 32'd1);
      chk("idle_wen",   32'(sram_we_n), 32'd1);
      chk("idle_oe",    32'(sram_dq_oe), 32'd0);

      // write 1024 <- DEADBEEF
      s0 = strobes;
      do_req(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, lows, res);
      chk("wr0_lows", 32'(lows), 32'd5);
      chk("wr0_m0",   32'(mem[0]), 32'h0000DEAD);
      chk("wr0_m1",   32'(mem[1]), 32'h0000BEEF);
      chk("wr0_strb", 32'(strobes - s0), 32'd2);

      // read it back, result must hold after enables drop
      do_req(1'b0, 1'b1, 32'd1024, 32'd0, lows, res);
      chk("rd0_lows", 32'(lows), 32'd5);
      chk("rd0_done", res, 32'hDEADBEEF);
      @(negedge clk);
      chk("rd0_hold", result, 32'hDEADBEEF);
      chk("rd0_rdy",  32'(ready), 32'd1);

      // unaligned write (low bits ignored), aligned read
      do_req(1'b1, 1'b0, 32'd1031, 32'h12345678, lows, res);
      chk("wr1_m2", 32'(mem[2]), 32'h00001234);
      chk("wr1_m3", 32'(mem[3]), 32'h00005678);
      do_req(1'b0, 1'b1, 32'd1028, 32'd0, lows, res);
      chk("rd1_done", res, 32'h12345678);

      // both enables: write wins, result untouched
      s0 = strobes;
      do_req(1'b1, 1'b1, 32'd1032, 32'hCAFEF00D, lows, res);
      chk("both_lows", 32'(lows), 32'd5);
      chk("both_m4",   32'(mem[4]), 32'h0000CAFE);
      chk("both_m5",   32'(mem[5]), 32'h0000F00D);
      chk("both_res",  res, 32'h12345678);
      chk("both_strb", 32'(strobes - s0), 32'd2);

      // address below base wraps: waddr[16:0]=0x1FF00 -> halfwords 0x3FE00/1
      do_req(1'b1, 1'b0, 32'd0, 32'hA5A55A5A, lows, res);
      chk("wrap_mhi", 32'(mem[18'h3FE00]), 32'h0000A5A5);
      chk("wrap_mlo", 32'(mem[18'h3FE01]), 32'h00005A5A);
      do_req(1'b0, 1'b1, 32'd0, 32'd0, lows, res);
      chk("wrap_rd", res, 32'hA5A55A5A);

      // reset during ACC_LO of a write (edge3 enters ACC_LO, strobe pending)
      @(posedge clk); #1;
      mem_w_en = 1'b1; address = 32'd1024; dataToWrite = 32'h11112222;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      chk("arst_wen",   32'(sram_we_n), 32'd1);
      chk("arst_oe",    32'(sram_dq_oe), 32'd0);
      chk("arst_addr",  32'(sram_addr), 32'd0);
      chk("arst_dqout", 32'(sram_dq_out), 32'd0);
      chk("arst_res",   result, 32'd0);
      mem_w_en = 1'b0;
      @(posedge clk); #1 rst = 1'b1;
      @(negedge clk);
      chk("arst_rdy", 32'(ready), 32'd1);
      @(negedge clk);
      chk("arst_m1",  32'(mem[1]), 32'h0000BEEF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
